// File: rtl/dcache_pkg.sv
// dcache_pkg: controller states, access-size encodings and store-lane helpers
// shared by the data cache and its storage array.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_WDONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Lane selection uses only the offset bits; misaligned halves/words are not faulted.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << off;
      SZ_HALF: store_be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: store_be = 4'b1111;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: store_lanes = {4{data[7:0]}};
      SZ_HALF: store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped tag/valid/data storage; asynchronous read and
// per-byte-lane write so a load hit returns data in the same cycle.
module dcache_array #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22,
  localparam int SB        = $clog2(SETS),
  localparam int WB        = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SB-1:0]    set_i,
  input  logic [WB-1:0]    word_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [31:0]      rdata_o,
  input  logic             wr_en_i,
  input  logic [WB-1:0]    wr_word_i,
  input  logic [3:0]       wr_be_i,
  input  logic [31:0]      wr_data_i,
  input  logic             line_we_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [SB+WB-1:0] rd_addr;
  logic [SB+WB-1:0] wr_addr;

  assign rd_addr = {set_i, word_i};
  assign wr_addr = {set_i, wr_word_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[set_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[set_i] <= tag_i;
    end
  end

  assign valid_o = valid_q[set_i];
  assign tag_o   = tag_q[set_i];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [SETS*LINE_WORDS];

      always_ff @(posedge clk) begin
        if (wr_en_i && wr_be_i[gi]) begin
          lane_q[wr_addr] <= wr_data_i[gi*8 +: 8];
        end
      end

      assign rdata_o[gi*8 +: 8] = lane_q[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped L1 data cache, write-through / no-write-allocate.
// Defining DCACHE_PERF_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module data_cache
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int SB = $clog2(SETS);
  localparam int TW = 30 - WB - SB;

  state_e        state_q, state_d;
  logic [WB-1:0] beat_q, beat_d;
  logic [WB-1:0] word_idx, wr_word;
  logic [SB-1:0] set_idx;
  logic [TW-1:0] tag, line_tag;
  logic          line_valid, hit, last_beat, fill_done, wr_en, stall;
  logic [3:0]    st_be, wr_be;
  logic [31:0]   st_data, wr_data, line_word, rdata;

  assign word_idx  = addr_i[2 +: WB];
  assign set_idx   = addr_i[2+WB +: SB];
  assign tag       = addr_i[31 -: TW];
  assign hit       = line_valid && (line_tag == tag);
  assign st_be     = store_be(size_i, addr_i[1:0]);
  assign st_data   = store_lanes(size_i, wdata_i);
  assign last_beat = &beat_q;

  dcache_array #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TW)) u_array (
    .clk       (clk),
    .rst       (rst),
    .set_i     (set_idx),
    .word_i    (word_idx),
    .tag_i     (tag),
    .valid_o   (line_valid),
    .tag_o     (line_tag),
    .rdata_o   (line_word),
    .wr_en_i   (wr_en),
    .wr_word_i (wr_word),
    .wr_be_i   (wr_be),
    .wr_data_i (wr_data),
    .line_we_i (fill_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    stall       = 1'b0;
    rdata       = 32'd0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    mem_be_o    = 4'b0000;
    wr_en       = 1'b0;
    wr_word     = word_idx;
    wr_be       = 4'b0000;
    wr_data     = 32'd0;
    fill_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i && we_i) begin
          stall   = 1'b1;
          state_d = ST_WRITE;
        end else if (req_i && hit) begin
          rdata = line_word;
        end else if (req_i) begin
          stall   = 1'b1;
          beat_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        stall      = 1'b1;
        mem_req_o  = 1'b1;
        mem_be_o   = 4'b1111;
        mem_addr_o = {addr_i[31:2+WB], beat_q, 2'b00};
        if (mem_ack_i) begin
          wr_en   = 1'b1;
          wr_word = beat_q;
          wr_be   = 4'b1111;
          wr_data = mem_rdata_i;
          beat_d  = beat_q + 1'b1;
          if (last_beat) begin
            fill_done = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        stall       = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_i[31:2], 2'b00};
        mem_be_o    = st_be;
        mem_wdata_o = st_data;
        if (mem_ack_i) begin
          // No write-allocate: only a line already holding this address is updated.
          wr_en   = hit;
          wr_be   = st_be;
          wr_data = st_data;
          state_d = ST_WDONE;
        end
      end
      ST_WDONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Held-off outputs depend on req_i combinationally, so gate them while in reset.
  assign stall_o = rst & stall;
  assign rdata_o = rst ? rdata : 32'd0;

`ifdef DCACHE_PERF_EN
  logic        refill_q, load_idle;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign load_idle = (state_q == ST_IDLE) && req_i && !we_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q <= fill_done;
      if (load_idle && hit && !refill_q && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (load_idle && !hit && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
